// File: rtl/pc_seq_if.sv
// pc_seq_if: control inputs and PC/run-state outputs of pc_seq (call/return signals under PC_RAS_EN)
interface pc_seq_if #(parameter int D = 12);
  logic         start, stall, halt, reljump_en, absjump_en;
  logic [D-1:0] offset, target, prog_ctr;
  logic         running, done;
`ifdef PC_RAS_EN
  logic         call_en, ret_en, ras_empty, ras_full;
`endif
  modport master (
    output start, stall, halt, reljump_en, absjump_en, offset, target,
`ifdef PC_RAS_EN
    output call_en, ret_en,
    input  ras_empty, ras_full,
`endif
    input  prog_ctr, running, done
  );
  modport slave (
    input  start, stall, halt, reljump_en, absjump_en, offset, target,
`ifdef PC_RAS_EN
    input  call_en, ret_en,
    output ras_empty, ras_full,
`endif
    output prog_ctr, running, done
  );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: fetch-stage PC sequencer with jumps, stall/halt and run handshake; PC_RAS_EN adds a return-address stack
module pc_seq #(
  parameter int           D          = 12,
  parameter logic [D-1:0] START_ADDR = '0,
  parameter int           RAS_DEPTH  = 4
) (
  input logic     clk,
  input logic     reset_n,
  pc_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d, top;
  logic         go, call, ret, pop_ok;
  // a PC-changing request is honoured only in RUN when neither halt nor stall is present
  assign go = (state_q == RUN) && !bus.halt && !bus.stall;
`ifdef PC_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [D-1:0]  ras_q [RAS_DEPTH];
  logic [D-1:0]  ras_d [RAS_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  assign call          = bus.call_en;
  assign ret           = bus.ret_en;
  assign pop_ok        = cnt_q != '0;
  assign full          = cnt_q == CW'(RAS_DEPTH);
  assign top           = ras_q[0];
  assign bus.ras_empty = !pop_ok;
  assign bus.ras_full  = full;
  // shift-register stack: entry 0 is the top, pushing when full drops the oldest entry off the end
  always_comb begin
    ras_d = ras_q;
    cnt_d = cnt_q;
    if (state_q != RUN) begin
      cnt_d = bus.start ? '0 : cnt_q;
    end else if (go && ret && pop_ok) begin
      for (int i = 0; i < RAS_DEPTH - 1; i++) ras_d[i] = ras_q[i+1];
      cnt_d = cnt_q - 1'b1;
    end else if (go && call && !ret) begin
      ras_d[0] = pc_q + 1'b1;
      for (int i = 1; i < RAS_DEPTH; i++) ras_d[i] = ras_q[i-1];
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
    end
  end
  // stack occupancy; reset empties the stack
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // stack entries carry no reset, the occupancy count marks which are valid
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end
`else
  assign call   = 1'b0;
  assign ret    = 1'b0;
  assign pop_ok = 1'b0;
  assign top    = '0;
`endif
  // state and PC registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  // start leaves IDLE/HALTED, halt leaves RUN
  always_comb begin
    state_d = (state_q == RUN) ? (bus.halt ? HALTED : RUN) : (bus.start ? RUN : state_q);
  end
  // next PC: return, then absolute jump/call, then relative jump, then increment; wrap is modulo 2^D
  always_comb begin
    pc_d = pc_q;
    if (state_q != RUN) pc_d = bus.start ? START_ADDR : pc_q;
    else if (go) pc_d = ret ? (pop_ok ? top : pc_q + 1'b1) :
                        (bus.absjump_en || call) ? bus.target :
                        bus.reljump_en ? pc_q + bus.offset : pc_q + 1'b1;
  end
  // outputs decoded from registered state
  always_comb begin
    bus.prog_ctr = pc_q;
    bus.running  = state_q == RUN;
    bus.done     = state_q == HALTED;
  end
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: table-driven check of pc_seq plus hand-written halt and return-stack sequences
module tb_pc_seq;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int failures = 0;
  pc_seq_if #(.D(12)) bus ();
  pc_seq #(.D(12)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic rn, st, sl, hl, rl, ab;
    logic [11:0] off, tgt, pc;
    logic run, dn;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    reset_n        = x.rn;
    bus.start      = x.st;
    bus.stall      = x.sl;
    bus.halt       = x.hl;
    bus.reljump_en = x.rl;
    bus.absjump_en = x.ab;
    bus.offset     = x.off;
    bus.target     = x.tgt;
`ifdef PC_RAS_EN
    bus.call_en    = 1'b0;
    bus.ret_en     = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input vec_t x, input string nm);
    drive(x);
    chk({nm, " pc"}, 32'(bus.prog_ctr), 32'(x.pc));
    chk({nm, " running"}, 32'(bus.running), 32'(x.run));
    chk({nm, " done"}, 32'(bus.done), 32'(x.dn));
  endtask
`ifdef PC_RAS_EN
  task automatic ras_step(input logic c, input logic r, input logic a, input logic [11:0] t,
                          input logic [11:0] pc, input logic e, input logic f, input string nm);
    reset_n        = 1'b1;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.halt       = 1'b0;
    bus.reljump_en = 1'b0;
    bus.absjump_en = a;
    bus.offset     = '0;
    bus.target     = t;
    bus.call_en    = c;
    bus.ret_en     = r;
    @(posedge clk);
    #1;
    chk({nm, " pc"}, 32'(bus.prog_ctr), 32'(pc));
    chk({nm, " ras_empty"}, 32'(bus.ras_empty), 32'(e));
    chk({nm, " ras_full"}, 32'(bus.ras_full), 32'(f));
  endtask
`endif
  initial begin
    //           rn st sl hl rl ab  off     tgt     pc    run dn
    v.push_back('{0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0});
    for (int i = 0; i < 5; i++) v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0});
    v.push_back('{1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h001, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h002, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h003, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h004, 1, 0});
    v.push_back('{1, 0, 1, 0, 0, 1, 12'h000, 12'h777, 12'h004, 1, 0});
    v.push_back('{1, 0, 1, 0, 1, 0, 12'h005, 12'h000, 12'h004, 1, 0});
    v.push_back('{1, 0, 0, 0, 1, 0, 12'hFFD, 12'h000, 12'h001, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 1, 12'h000, 12'h005, 12'h005, 1, 0});
    v.push_back('{1, 0, 0, 0, 1, 1, 12'h010, 12'h080, 12'h080, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 1, 12'h000, 12'h005, 12'h005, 1, 0});
    v.push_back('{1, 0, 0, 1, 1, 1, 12'h010, 12'h080, 12'h005, 0, 1});
    v.push_back('{1, 0, 1, 0, 1, 1, 12'h010, 12'h123, 12'h005, 0, 1});
    v.push_back('{1, 0, 0, 1, 0, 0, 12'h000, 12'h000, 12'h005, 0, 1});
    v.push_back('{1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 1, 12'h000, 12'hFFE, 12'hFFE, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'hFFF, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0});
    v.push_back('{1, 0, 0, 0, 1, 0, 12'h002, 12'h000, 12'h002, 1, 0});
    v.push_back('{1, 0, 0, 0, 1, 0, 12'hFFD, 12'h000, 12'hFFF, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 1, 12'h000, 12'h01F, 12'h01F, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h020, 1, 0});
    v.push_back('{1, 0, 0, 1, 0, 0, 12'h000, 12'h000, 12'h020, 0, 1});
    v.push_back('{1, 0, 0, 0, 1, 1, 12'h004, 12'h333, 12'h020, 0, 1});
    v.push_back('{1, 0, 0, 0, 1, 0, 12'h005, 12'h000, 12'h020, 0, 1});
    v.push_back('{1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h001, 1, 0});
    v.push_back('{1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h002, 1, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h003, 1, 0});
    v.push_back('{0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0});
    v.push_back('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0});
    foreach (v[i]) apply(v[i], $sformatf("vec%0d", i));
    apply('{1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0}, "seq start");
    apply('{1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h001, 1, 0}, "seq inc");
    apply('{1, 0, 1, 1, 0, 1, 12'h000, 12'h444, 12'h001, 0, 1}, "seq halt over stall");
    apply('{0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0}, "seq reset from halted");
`ifdef PC_RAS_EN
    apply('{1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0}, "ras start");
    ras_step(0, 0, 1, 12'h010, 12'h010, 1, 0, "ras jmp");
    ras_step(1, 0, 0, 12'h100, 12'h100, 0, 0, "ras call1");
    ras_step(0, 1, 0, 12'h000, 12'h011, 1, 0, "ras ret1");
    ras_step(1, 0, 0, 12'h200, 12'h200, 0, 0, "ras c1");
    ras_step(1, 0, 0, 12'h300, 12'h300, 0, 0, "ras c2");
    ras_step(1, 0, 0, 12'h400, 12'h400, 0, 0, "ras c3");
    ras_step(1, 0, 0, 12'h500, 12'h500, 0, 1, "ras c4");
    ras_step(1, 0, 0, 12'h600, 12'h600, 0, 1, "ras c5");
    ras_step(0, 1, 0, 12'h000, 12'h501, 0, 0, "ras r1");
    ras_step(0, 1, 0, 12'h000, 12'h401, 0, 0, "ras r2");
    ras_step(0, 1, 0, 12'h000, 12'h301, 0, 0, "ras r3");
    ras_step(0, 1, 0, 12'h000, 12'h201, 1, 0, "ras r4");
    ras_step(0, 1, 0, 12'h000, 12'h202, 1, 0, "ras r5 empty");
    ras_step(1, 1, 0, 12'h700, 12'h203, 1, 0, "ras call+ret");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
